// File: rtl/mano_pkg.sv
// Shared types for the SRAM arbiter slice.
// FSM states, owner encoding and default bus widths.
package mano_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  typedef enum logic {
    CPU  = 1'b0,
    HOST = 1'b1
  } owner_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester-side req/ack bus into the SRAM arbiter.
// master = requester, slave = arbiter.
interface sram_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
) ();

  logic                  req;
  logic                  we_n;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ack;

  modport master (
    output req, we_n, addr, wdata,
    input  rdata, ack
  );

  modport slave (
    input  req, we_n, addr, wdata,
    output rdata, ack
  );

endinterface

// File: rtl/arb_pick.sv
// Grant selection between CPU and host requests.
// ARB_HOST_PRIORITY_EN: host wins ties, last grant ignored.
module arb_pick
  import mano_pkg::*;
(
  input  logic   cpu_elig,
  input  logic   host_elig,
  input  owner_t last,
  output logic   grant,
  output owner_t pick
);

`ifdef ARB_HOST_PRIORITY_EN
  logic unused_last;
  assign unused_last = last;
`endif

  always_comb begin
    grant = cpu_elig | host_elig;
    pick  = CPU;
    if (cpu_elig && host_elig) begin
`ifdef ARB_HOST_PRIORITY_EN
      pick = HOST;
`else
      pick = (last == CPU) ? HOST : CPU;
`endif
    end else if (host_elig) begin
      pick = HOST;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one synchronous SRAM between CPU and host ports.
// Optional ARB_HOST_PRIORITY_EN: host always wins ties.
module sram_arbiter #(
  parameter int DATA_WIDTH = mano_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = mano_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  sram_arbiter_if.slave         cpu,
  sram_arbiter_if.slave         host,
  output logic                  mem_we_n,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  import mano_pkg::*;

  state_t state_q, state_d;
  owner_t own_q, last_q, pick;
  logic   grant;
  logic   rd_q;
  logic   cpu_elig, host_elig;

  logic                  sel_we_n;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  // A port in its ack cycle has not yet issued its next request.
  assign cpu_elig  = cpu.req & ~cpu.ack;
  assign host_elig = host.req & ~host.ack;

  arb_pick u_pick (
    .cpu_elig  (cpu_elig),
    .host_elig (host_elig),
    .last      (last_q),
    .grant     (grant),
    .pick      (pick)
  );

  always_comb begin
    sel_we_n  = cpu.we_n;
    sel_addr  = cpu.addr;
    sel_wdata = cpu.wdata;
    if (pick == HOST) begin
      sel_we_n  = host.we_n;
      sel_addr  = host.addr;
      sel_wdata = host.wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant) state_d = ADDR;
      ADDR:    state_d = DATA;
      DATA:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // SRAM drive is loaded on grant so it is valid for the whole ADDR cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      own_q     <= CPU;
      rd_q      <= 1'b1;
      mem_we_n  <= 1'b1;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we_n <= 1'b1;
      if (state_q == IDLE && grant) begin
        own_q     <= pick;
        rd_q      <= sel_we_n;
        mem_we_n  <= sel_we_n;
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q     <= HOST;
      cpu.ack    <= 1'b0;
      host.ack   <= 1'b0;
      cpu.rdata  <= '0;
      host.rdata <= '0;
    end else begin
      cpu.ack  <= (state_q == DATA) && (own_q == CPU);
      host.ack <= (state_q == DATA) && (own_q == HOST);
      if (state_q == DATA) begin
        last_q <= own_q;
        if (rd_q && own_q == CPU)  cpu.rdata  <= mem_rdata;
        if (rd_q && own_q == HOST) host.rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural
// synchronous SRAM model.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_we_n;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  always #5 clk = ~clk;

  sram_arbiter_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) cpu_bus ();
  sram_arbiter_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) host_bus ();

  sram_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu       (cpu_bus),
    .host      (host_bus),
    .mem_we_n  (mem_we_n),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  logic [15:0] mem [0:1023];

  always @(posedge clk) begin
    if (!mem_we_n) mem[mem_addr[9:0]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[9:0]];
  end

  int cyc;
  int we_low;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (mem_we_n === 1'b0) we_low <= we_low + 1;

  int checks;
  int errors;

  typedef struct {
    bit          h;
    logic        we_n;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] exp;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit h, input logic req, input logic we_n,
                       input logic [15:0] a, input logic [15:0] d);
    if (h) begin
      host_bus.req   = req;
      host_bus.we_n  = we_n;
      host_bus.addr  = a;
      host_bus.wdata = d;
    end else begin
      cpu_bus.req   = req;
      cpu_bus.we_n  = we_n;
      cpu_bus.addr  = a;
      cpu_bus.wdata = d;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic access(input bit h, input logic we_n,
                        input logic [15:0] a, input logic [15:0] d,
                        output int lat, output logic [15:0] rd,
                        output int ack_cyc);
    logic ack;
    @(negedge clk);
    drive(h, 1'b1, we_n, a, d);
    lat = 0;
    ack = 1'b0;
    while (!ack && lat < 20) begin
      @(negedge clk);
      lat++;
      ack = h ? host_bus.ack : cpu_bus.ack;
    end
    ack_cyc = cyc;
    rd = h ? host_bus.rdata : cpu_bus.rdata;
    drive(h, 1'b0, 1'b1, a, d);
  endtask

  task automatic both_req(input logic cwe, input logic [15:0] ca,
                          input logic [15:0] cd, input logic hwe,
                          input logic [15:0] ha, input logic [15:0] hd,
                          output int c_at, output int h_at,
                          output logic [15:0] c_rd,
                          output logic [15:0] h_rd);
    int n;
    @(negedge clk);
    drive(1'b0, 1'b1, cwe, ca, cd);
    drive(1'b1, 1'b1, hwe, ha, hd);
    n = 0;
    c_at = 0;
    h_at = 0;
    c_rd = '0;
    h_rd = '0;
    while ((c_at == 0 || h_at == 0) && n < 30) begin
      @(negedge clk);
      n++;
      if (cpu_bus.ack) begin
        c_at = n;
        c_rd = cpu_bus.rdata;
        cpu_bus.req = 1'b0;
      end
      if (host_bus.ack) begin
        h_at = n;
        h_rd = host_bus.rdata;
        host_bus.req = 1'b0;
      end
    end
    cpu_bus.req = 1'b0;
    host_bus.req = 1'b0;
  endtask

  initial begin
    int lat, lat2, a1, a2, w0, n, nc, nh, last_who, alt_err, done_at;
    int c_at, h_at, seen;
    logic [15:0] rd, c_rd, h_rd;

    checks = 0;
    errors = 0;
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
    drive(1'b1, 1'b0, 1'b1, 16'h0, 16'h0);

    vt[0] = '{1'b1, 1'b0, 16'd10, 16'h1111, 16'h0000};
    vt[1] = '{1'b0, 1'b1, 16'd10, 16'h0000, 16'h1111};
    vt[2] = '{1'b0, 1'b0, 16'd11, 16'h2222, 16'h1111};
    vt[3] = '{1'b1, 1'b1, 16'd11, 16'h0000, 16'h2222};
    vt[4] = '{1'b0, 1'b0, 16'd0,  16'hFFFF, 16'h1111};
    vt[5] = '{1'b0, 1'b1, 16'd0,  16'h0000, 16'hFFFF};
    vt[6] = '{1'b1, 1'b1, 16'd10, 16'h0000, 16'h1111};
    vt[7] = '{1'b0, 1'b0, 16'd12, 16'hA5A5, 16'hFFFF};
    vt[8] = '{1'b1, 1'b0, 16'd12, 16'h5A5A, 16'h1111};
    vt[9] = '{1'b0, 1'b1, 16'd12, 16'h0000, 16'h5A5A};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("idle%0d_we_ack", i),
          {29'd0, mem_we_n, cpu_bus.ack, host_bus.ack}, 32'd4);
    end
    chk("idle_mem_addr", mem_addr, 32'd0);
    chk("idle_mem_wdata", mem_wdata, 32'd0);
    chk("idle_rdata", {cpu_bus.rdata, host_bus.rdata}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      access(vt[i].h, vt[i].we_n, vt[i].a, vt[i].d, lat, rd, a1);
      chk($sformatf("vec%0d_lat", i), lat, 32'd3);
      chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp);
      @(negedge clk);
      chk($sformatf("vec%0d_ack_pulse", i),
          {30'd0, cpu_bus.ack, host_bus.ack}, 32'd0);
    end

    w0 = we_low;
    access(1'b1, 1'b0, 16'd300, 16'h00AB, lat, rd, a1);
    access(1'b1, 1'b1, 16'd300, 16'h0000, lat2, rd, a2);
    @(negedge clk);
    chk("host_wr_lat", lat, 32'd3);
    chk("host_rd_gap", a2 - a1, 32'd4);
    chk("host_rd_data", rd, 32'h00AB);
    chk("host_we_low_cycles", we_low - w0, 32'd1);

    access(1'b1, 1'b0, 16'd0, 16'h7001, lat, rd, a1);
    access(1'b1, 1'b0, 16'd100, 16'h0055, lat, rd, a1);
    pulse_reset();
    both_req(1'b1, 16'd0, 16'h0, 1'b1, 16'd100, 16'h0,
             c_at, h_at, c_rd, h_rd);
    chk("tie_cpu_ack_at", c_at, 32'd3);
    chk("tie_host_ack_at", h_at, 32'd6);
    chk("tie_cpu_rdata", c_rd, 32'h7001);
    chk("tie_host_rdata", h_rd, 32'h0055);

    pulse_reset();
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 16'd1, 16'h0);
    drive(1'b1, 1'b1, 1'b1, 16'd2, 16'h0);
    n = 0;
    nc = 0;
    nh = 0;
    last_who = -1;
    alt_err = 0;
    done_at = 0;
    while (nc + nh < 16 && n < 100) begin
      @(negedge clk);
      n++;
      if (cpu_bus.ack) begin
        if (last_who == 0) alt_err++;
        last_who = 0;
        nc++;
        if (nc == 8) cpu_bus.req = 1'b0;
      end
      if (host_bus.ack) begin
        if (last_who == 1) alt_err++;
        last_who = 1;
        nh++;
        if (nh == 8) host_bus.req = 1'b0;
      end
      if (nc + nh == 16) done_at = n;
    end
    cpu_bus.req = 1'b0;
    host_bus.req = 1'b0;
    chk("rr_cpu_acks", nc, 32'd8);
    chk("rr_host_acks", nh, 32'd8);
    chk("rr_alternation", alt_err, 32'd0);
    chk("rr_16_acks_cycles", done_at, 32'd48);

    pulse_reset();
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 16'd200, 16'h1234);
    @(negedge clk);
    chk("rst_mid_addr_we_low", mem_we_n, 32'd0);
    reset = 1'b1;
    #1;
    chk("rst_async_we_high", mem_we_n, 32'd1);
    drive(1'b0, 1'b0, 1'b1, 16'd200, 16'h0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (cpu_bus.ack || mem_we_n !== 1'b1) seen++;
    end
    chk("rst_no_ack_no_we", seen, 32'd0);
    access(1'b0, 1'b1, 16'd10, 16'h0, lat, rd, a1);
    chk("rst_then_idle_lat", lat, 32'd3);
    chk("rst_then_rdata", rd, 32'h1111);

    pulse_reset();
    both_req(1'b0, 16'd300, 16'h0042, 1'b1, 16'd300, 16'h0,
             c_at, h_at, c_rd, h_rd);
    chk("raw_cpu_ack_at", c_at, 32'd3);
    chk("raw_host_ack_at", h_at, 32'd6);
    chk("raw_host_rdata", h_rd, 32'h0042);
    chk("raw_cpu_rdata_kept", c_rd, 32'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
